pwm_duty_ramp_ctrl: RTL and testbench

//   Soft-start / slew controller for the PWM clock divider's 8-bit dutyCycle input (percent, 0..100).

---
 rtl/pwm_duty_ramp_ctrl_if.sv | 18 +
 rtl/pwm_duty_ramp_ctrl.sv | 104 ++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Target-duty handshake between the control logic and the duty ramp controller.
interface pwm_duty_ramp_ctrl_if;
  logic [7:0] target;
  logic       target_valid;
  logic       target_ready;

  modport master (
    output target,
    output target_valid,
    input  target_ready
  );

  modport slave (
    input  target,
    input  target_valid,
    output target_ready
  );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start / slew controller: walks the divider's duty toward a requested target,
// changing it only on PWM period boundaries.
module pwm_duty_ramp_ctrl #(
  parameter int unsigned PERIOD_CLKS      = 5000,
  parameter int unsigned STEP             = 5,
  parameter int unsigned PERIODS_PER_STEP = 4,
  parameter int unsigned INIT_DUTY        = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  pwm_duty_ramp_ctrl_if.slave        tgtIf,
  input  logic                       hold,
  output logic [7:0]                 duty_out,
  output logic                       period_tick,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned PeriodW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam int unsigned StepW   = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(PERIOD_CLKS - 1);
  localparam logic [StepW-1:0]   StepLast   = StepW'(PERIODS_PER_STEP - 1);
  localparam logic [7:0]         StepAmt    = 8'(STEP);
  localparam logic [7:0]         InitDuty   = 8'(INIT_DUTY);

  typedef enum logic [0:0] {StIdle, StRamp} state_e;

  state_e             stateQ, stateD;
  logic [PeriodW-1:0] periodCntQ;
  logic [StepW-1:0]   stepCntQ, stepCntD;
  logic [7:0]         dutyQ, dutyD, tgtQ, tgtD, tgtIn, diff, stepDuty;
  logic               readyQ, doneQ, doneD;
  logic               periodTick, accept, stepEdge, settle;

  assign periodTick = (periodCntQ == PeriodLast);

  always_comb begin
    tgtIn    = (tgtIf.target > 8'd100) ? 8'd100 : tgtIf.target;
    accept   = tgtIf.target_valid & readyQ;
    stepEdge = (stateQ == StRamp) & periodTick & ~hold & (stepCntQ == StepLast);
    // Magnitude is taken before subtracting so the difference never wraps.
    if (tgtQ >= dutyQ) begin
      diff     = tgtQ - dutyQ;
      stepDuty = (diff <= StepAmt) ? tgtQ : dutyQ + StepAmt;
    end else begin
      diff     = dutyQ - tgtQ;
      stepDuty = (diff <= StepAmt) ? tgtQ : dutyQ - StepAmt;
    end
    // A step on the accept edge still uses the old target.
    tgtD   = accept ? tgtIn : tgtQ;
    dutyD  = stepEdge ? stepDuty : dutyQ;
    settle = (accept | stepEdge) & (dutyD == tgtD);
    doneD  = settle;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= StIdle;
    else     stateQ <= stateD;
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    if (settle)      stateD = StIdle;
    else if (accept) stateD = StRamp;
  end

  always_comb begin
    stepCntD = stepCntQ;
    if ((stateQ == StRamp) && periodTick && !hold) begin
      stepCntD = (stepCntQ == StepLast) ? '0 : stepCntQ + 1'b1;
    end
    if (stateD == StIdle) stepCntD = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      periodCntQ <= '0;
      stepCntQ   <= '0;
      dutyQ      <= InitDuty;
      tgtQ       <= InitDuty;
      readyQ     <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      periodCntQ <= periodTick ? '0 : periodCntQ + 1'b1;
      stepCntQ   <= stepCntD;
      dutyQ      <= dutyD;
      tgtQ       <= tgtD;
      readyQ     <= 1'b1;
      doneQ      <= doneD;
    end
  end

  // Outputs.
  always_comb begin
    busy                = (stateQ == StRamp);
    done                = doneQ;
    duty_out            = dutyQ;
    period_tick         = periodTick;
    tgtIf.target_ready  = readyQ;
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl with a 10-clock period and 2 periods per step.
module tb_pwm_duty_ramp_ctrl;

  logic       clk;
  logic       rst;
  logic       hold;
  logic [7:0] duty_out;
  logic       period_tick;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastStepCyc = -1;
  int donePulses = 0;
  int base;
  int changes;
  logic [7:0] prevDuty;

  pwm_duty_ramp_ctrl_if bus ();

  pwm_duty_ramp_ctrl #(
    .PERIOD_CLKS     (10),
    .STEP            (5),
    .PERIODS_PER_STEP(2),
    .INIT_DUTY       (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tgtIf      (bus.slave),
    .hold       (hold),
    .duty_out   (duty_out),
    .period_tick(period_tick),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) donePulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle; cyc counts edges since the last reset release.
  task automatic tick1();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    lastStepCyc = -1;
  endtask

  task automatic sendTarget(input logic [7:0] v);
    bus.target       = v;
    bus.target_valid = 1'b1;
    tick1();
    bus.target_valid = 1'b0;
  endtask

  task automatic waitStep(input int expDuty, input int finalTgt);
    logic [7:0] prev;
    bit seen;
    prev = duty_out;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick1();
      if (duty_out !== prev) seen = 1'b1;
    end
    check($sformatf("step_seen_%0d", expDuty), 32'(seen), 1);
    check($sformatf("step_value_%0d", expDuty), 32'(duty_out), expDuty);
    check($sformatf("step_aligned_%0d", expDuty), cyc % 10, 0);
    if (lastStepCyc >= 0) check($sformatf("step_interval_%0d", expDuty), cyc - lastStepCyc, 20);
    lastStepCyc = cyc;
    check($sformatf("step_busy_%0d", expDuty), 32'(busy), 32'(expDuty != finalTgt));
    check($sformatf("step_done_%0d", expDuty), 32'(done), 32'(expDuty == finalTgt));
  endtask

  initial begin
    rst              = 1'b1;
    hold             = 1'b0;
    bus.target       = 8'd0;
    bus.target_valid = 1'b0;

    // 1: reset state, ready release, period tick cadence
    @(posedge clk);
    #1;
    check("rst_duty", 32'(duty_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(bus.target_ready), 0);
    check("rst_tick", 32'(period_tick), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    check("ready_before_edge", 32'(bus.target_ready), 0);
    tick1();
    check("ready_after_release", 32'(bus.target_ready), 1);
    for (int i = 0; i < 24; i++) begin
      check($sformatf("period_tick_c%0d", cyc), 32'(period_tick), 32'((cyc % 10) == 9));
      tick1();
    end

    // 2: ramp 0 -> 90
    base = donePulses;
    sendTarget(8'd90);
    check("up_busy_start", 32'(busy), 1);
    for (int k = 1; k <= 18; k++) waitStep(5 * k, 90);
    tick1();
    check("up_done_single", 32'(done), 0);
    check("up_idle", 32'(busy), 0);
    check("up_done_count", donePulses - base, 1);

    // 3a: partial final step 90 -> 73
    base = donePulses;
    lastStepCyc = -1;
    sendTarget(8'd73);
    waitStep(85, 73);
    waitStep(80, 73);
    waitStep(75, 73);
    waitStep(73, 73);
    tick1();
    check("down_done_count", donePulses - base, 1);

    // 3b: clamp 150 -> 100 from 0
    doReset();
    tick1();
    base = donePulses;
    sendTarget(8'd150);
    for (int k = 1; k <= 20; k++) waitStep(5 * k, 100);
    changes = 0;
    prevDuty = duty_out;
    for (int i = 0; i < 40; i++) begin
      tick1();
      if (duty_out !== prevDuty) changes++;
    end
    check("clamp_stays", changes, 0);
    check("clamp_duty", 32'(duty_out), 100);
    check("clamp_done_count", donePulses - base, 1);

    // 4: retarget mid-ramp, step counter keeps its phase
    doReset();
    tick1();
    base = donePulses;
    sendTarget(8'd50);
    for (int k = 1; k <= 4; k++) waitStep(5 * k, 50);
    repeat (12) tick1();
    sendTarget(8'd10);
    check("retgt_busy", 32'(busy), 1);
    waitStep(15, 10);
    waitStep(10, 10);
    tick1();
    check("retgt_done_count", donePulses - base, 1);
    check("retgt_idle", 32'(busy), 0);

    // 5: hold freezes duty, then target equal to duty
    lastStepCyc = -1;
    sendTarget(8'd60);
    for (int k = 3; k <= 8; k++) waitStep(5 * k, 60);
    hold = 1'b1;
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      tick1();
      if (duty_out !== 8'd40) changes++;
    end
    check("hold_changes", changes, 0);
    check("hold_busy", 32'(busy), 1);
    hold = 1'b0;
    lastStepCyc = -1;
    for (int k = 9; k <= 12; k++) waitStep(5 * k, 60);
    tick1();
    base = donePulses;
    sendTarget(8'd60);
    check("equal_done", 32'(done), 1);
    check("equal_busy", 32'(busy), 0);
    tick1();
    check("equal_done_clear", 32'(done), 0);
    check("equal_busy_after", 32'(busy), 0);
    check("equal_done_count", donePulses - base, 1);

    // 6: asynchronous reset mid-ramp
    doReset();
    tick1();
    sendTarget(8'd50);
    for (int k = 1; k <= 7; k++) waitStep(5 * k, 50);
    repeat (5) tick1();
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_duty", 32'(duty_out), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_ready", 32'(bus.target_ready), 0);
    base = donePulses;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    changes = 0;
    for (int i = 0; i < 30; i++) begin
      tick1();
      if (duty_out !== 8'd0 || busy !== 1'b0) changes++;
    end
    check("post_rst_quiet", changes, 0);
    check("post_rst_no_done", donePulses - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
